// File: rtl/stage_ctrl_pkg.sv
// Shared stage encodings and opcode constants for the MLP stage sequencer.
// The stage enum is one-hot so it drives the stat vector directly.
package stage_ctrl_pkg;

  localparam int STAT_W_DEF = 5;
  localparam int DATA_W_DEF = 16;

  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;
  localparam int ST_WB  = 4;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00000,
    S_IF   = 5'b00001,
    S_ID   = 5'b00010,
    S_EX   = 5'b00100,
    S_MEM  = 5'b01000,
    S_WB   = 5'b10000
  } stage_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BNEQ = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/stage_ctrl_if.sv
// Sequencer-facing bundle: instruction fetch data, unit status in, stage/control out.
// master drives the inputs of the sequencer, slave is the sequencer itself.
interface stage_ctrl_if #(
  parameter int STAT_W = 5,
  parameter int DATA_W = 16
);
  logic              start;
  logic [DATA_W-1:0] inst;
  logic              ex_busy;
  logic              ne;
  logic              mem_ready;
  logic [STAT_W-1:0] stat;
  logic [DATA_W-1:0] ir;
  logic              mem_req;
  logic [7:0]        imm_bneq;
  logic              halted;

  modport master (
    output start, inst, ex_busy, ne, mem_ready,
    input  stat, ir, mem_req, imm_bneq, halted
  );

  modport slave (
    input  start, inst, ex_busy, ne, mem_ready,
    output stat, ir, mem_req, imm_bneq, halted
  );
endinterface

// File: rtl/stage_ctrl.sv
// Multi-cycle stage sequencer: IF -> ID -> EX (-> MEM) -> WB, HALT returns to IDLE.
// stat/ir/halted registered; mem_req and imm_bneq decoded from registered state.
module stage_ctrl
  import stage_ctrl_pkg::*;
#(
  parameter int STAT_W = STAT_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  stage_ctrl_if.slave   bus
);

  stage_e            state_q;
  logic [DATA_W-1:0] ir_q;
  logic              ne_q;
  logic              halted_q;

  logic [3:0] ir_op;
  logic [3:0] inst_op;

  assign ir_op   = ir_q[15:12];
  assign inst_op = bus.inst[15:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      ne_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q  <= S_IF;
            halted_q <= 1'b0;
          end
        end
        S_IF:  state_q <= S_ID;
        S_ID: begin
          ir_q <= bus.inst;
          // Decode the incoming word, not ir_q, which still holds the previous instruction.
          if (inst_op == OP_HALT) begin
            state_q  <= S_IDLE;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_EX;
          end
        end
        S_EX: begin
          if (!bus.ex_busy) begin
            ne_q    <= bus.ne;
            state_q <= is_mem_op(ir_op) ? S_MEM : S_WB;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) state_q <= S_WB;
        end
        S_WB:    state_q <= S_IF;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.stat     = STAT_W'(state_q);
  assign bus.ir       = ir_q;
  assign bus.halted   = halted_q;
  assign bus.mem_req  = (state_q == S_MEM);
  assign bus.imm_bneq = ((state_q == S_WB) && (ir_op == OP_BNEQ) && ne_q) ? ir_q[7:0] : 8'h00;

endmodule

// File: tb/tb_stage_ctrl.sv
// Scoreboard bench for stage_ctrl: each driven cycle pushes its expected outputs,
// popped and compared at the following falling edge.
module tb_stage_ctrl;

  logic clk;
  logic rst;

  stage_ctrl_if #(.STAT_W(5), .DATA_W(16)) bus ();

  stage_ctrl #(.STAT_W(5), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  stat;
    logic        mreq;
    logic [7:0]  imm;
    logic        halted;
    logic [15:0] ir;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] prev_ir;
  logic        start_noise;

  localparam logic [4:0] E_IDLE = 5'b00000;
  localparam logic [4:0] E_IF   = 5'b00001;
  localparam logic [4:0] E_ID   = 5'b00010;
  localparam logic [4:0] E_EX   = 5'b00100;
  localparam logic [4:0] E_MEM  = 5'b01000;
  localparam logic [4:0] E_WB   = 5'b10000;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] s, input logic m, input logic [7:0] i,
                              input logic h, input logic [15:0] r);
    exp_t e;
    e.stat = s; e.mreq = m; e.imm = i; e.halted = h; e.ir = r;
    return e;
  endfunction

  // Drive one cycle of inputs, queue its expected outputs, compare mid-cycle.
  task automatic step(input logic st, input logic [15:0] in, input logic busy, input logic n,
                      input logic mr, input logic r, input exp_t e);
    exp_t x;
    bus.start = st; bus.inst = in; bus.ex_busy = busy; bus.ne = n; bus.mem_ready = mr;
    rst = r;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    chk("stat",     32'(bus.stat),     32'(x.stat));
    chk("mem_req",  32'(bus.mem_req),  32'(x.mreq));
    chk("imm_bneq", 32'(bus.imm_bneq), 32'(x.imm));
    chk("halted",   32'(bus.halted),   32'(x.halted));
    chk("ir",       32'(bus.ir),       32'(x.ir));
    @(posedge clk);
    #1;
  endtask

  // Entered in the IF cycle; returns in the cycle after WB (or after the HALT IDLE cycle).
  task automatic run_instr(input logic [15:0] instr, input logic n, input int busy_n, input int mem_wait);
    logic [3:0] op;
    logic [7:0] imm;
    op = instr[15:12];
    step(start_noise, instr, 1'b0, n, 1'b0, 1'b0, mk(E_IF, 1'b0, 8'h00, 1'b0, prev_ir));
    step(start_noise, instr, 1'b0, n, 1'b0, 1'b0, mk(E_ID, 1'b0, 8'h00, 1'b0, prev_ir));
    prev_ir = instr;
    if (op == 4'hF) begin
      step(1'b0, instr, 1'b0, n, 1'b0, 1'b0, mk(E_IDLE, 1'b0, 8'h00, 1'b1, instr));
      return;
    end
    for (int b = 0; b <= busy_n; b++)
      step(start_noise, instr, (b < busy_n), n, 1'b0, 1'b0, mk(E_EX, 1'b0, 8'h00, 1'b0, instr));
    if (op == 4'h8 || op == 4'h9)
      for (int m = 0; m <= mem_wait; m++)
        step(start_noise, instr, 1'b0, n, (m == mem_wait), 1'b0, mk(E_MEM, 1'b1, 8'h00, 1'b0, instr));
    imm = (op == 4'hB && n) ? instr[7:0] : 8'h00;
    step(start_noise, instr, 1'b0, n, 1'b0, 1'b0, mk(E_WB, 1'b0, imm, 1'b0, instr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.inst = '0; bus.ex_busy = 1'b0; bus.ne = 1'b0; bus.mem_ready = 1'b0;
    prev_ir = 16'h0000;
    start_noise = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(E_IDLE, 1'b0, 8'h00, 1'b0, 16'h0));
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(E_IDLE, 1'b0, 8'h00, 1'b0, 16'h0));
    step(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(E_IDLE, 1'b0, 8'h00, 1'b0, 16'h0));

    run_instr(16'h0000, 1'b0, 0, 0);
    run_instr(16'hB005, 1'b1, 0, 0);
    run_instr(16'hB005, 1'b0, 0, 0);
    run_instr(16'h00AA, 1'b1, 0, 0);
    run_instr(16'h8000, 1'b0, 0, 3);
    run_instr(16'h9012, 1'b1, 0, 0);
    start_noise = 1'b1;
    run_instr(16'h0000, 1'b0, 2, 0);
    start_noise = 1'b0;
    run_instr(16'hB0F7, 1'b1, 1, 0);

    run_instr(16'hF000, 1'b0, 0, 0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(E_IDLE, 1'b0, 8'h00, 1'b1, 16'hF000));
    step(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(E_IDLE, 1'b0, 8'h00, 1'b1, 16'hF000));
    run_instr(16'h0000, 1'b0, 0, 0);

    // Reset in the middle of a memory stall.
    step(1'b0, 16'h8123, 1'b0, 1'b0, 1'b0, 1'b0, mk(E_IF,  1'b0, 8'h00, 1'b0, 16'h0000));
    step(1'b0, 16'h8123, 1'b0, 1'b0, 1'b0, 1'b0, mk(E_ID,  1'b0, 8'h00, 1'b0, 16'h0000));
    step(1'b0, 16'h8123, 1'b0, 1'b0, 1'b0, 1'b0, mk(E_EX,  1'b0, 8'h00, 1'b0, 16'h8123));
    step(1'b0, 16'h8123, 1'b0, 1'b0, 1'b0, 1'b0, mk(E_MEM, 1'b1, 8'h00, 1'b0, 16'h8123));
    step(1'b0, 16'h8123, 1'b0, 1'b0, 1'b0, 1'b1, mk(E_MEM, 1'b1, 8'h00, 1'b0, 16'h8123));
    step(1'b0, 16'h8123, 1'b0, 1'b0, 1'b0, 1'b0, mk(E_IDLE, 1'b0, 8'h00, 1'b0, 16'h0000));
    prev_ir = 16'h0000;
    step(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, mk(E_IDLE, 1'b0, 8'h00, 1'b0, 16'h0000));
    run_instr(16'hB003, 1'b1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
